// File: rtl/neuron_accumulator_if.sv
// Stream interface for the neuron accumulator. It carries the start/config
// inputs, the activation/weight beats, and the result strobe.
interface neuron_accumulator_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int ACC_WIDTH   = 32,
    parameter int COUNT_WIDTH = 11
);
    logic                   start_in;
    logic [COUNT_WIDTH-1:0] num_inputs_in;
    logic [DATA_WIDTH-1:0]  bias_in;
    logic                   data_valid_in;
    logic [DATA_WIDTH-1:0]  activation_in;
    logic [DATA_WIDTH-1:0]  weight_in;
    logic                   data_ready_out;
    logic                   busy_out;
    logic                   acc_valid_out;
    logic [ACC_WIDTH-1:0]   acc_data_out;

    modport master (
        output start_in, num_inputs_in, bias_in, data_valid_in, activation_in, weight_in,
        input  data_ready_out, busy_out, acc_valid_out, acc_data_out
    );

    modport slave (
        input  start_in, num_inputs_in, bias_in, data_valid_in, activation_in, weight_in,
        output data_ready_out, busy_out, acc_valid_out, acc_data_out
    );
endinterface

// File: rtl/neuron_accumulator.sv
// Streaming signed MAC for one neuron: bias plus N activation*weight products.
// A registered product stage feeds a wrapping ACC_WIDTH accumulator.
module neuron_accumulator #(
    parameter int DATA_WIDTH  = 16,
    parameter int ACC_WIDTH   = 32,
    parameter int MAX_INPUTS  = 1024,
    parameter int COUNT_WIDTH = $clog2(MAX_INPUTS + 1)
) (
    input logic                 clk_in,
    input logic                 rst_in,
    neuron_accumulator_if.slave bus
);
    localparam int PROD_WIDTH = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    state_t                        state_q, state_d;
    logic [COUNT_WIDTH-1:0]        count_q;
    logic signed [PROD_WIDTH-1:0]  prod_q;
    logic                          prod_valid_q;
    logic signed [ACC_WIDTH-1:0]   acc_q;
    logic signed [ACC_WIDTH-1:0]   acc_sum;
    logic signed [ACC_WIDTH-1:0]   result_q;
    logic signed [DATA_WIDTH-1:0]  act_s, wt_s, bias_s;
    logic                          start_ok, accept, last_beat;

    assign act_s     = bus.activation_in;
    assign wt_s      = bus.weight_in;
    assign bias_s    = bus.bias_in;
    assign start_ok  = (state_q == IDLE) && bus.start_in;
    assign accept    = (state_q == ACCUM) && bus.data_valid_in;
    assign last_beat = accept && (count_q == COUNT_WIDTH'(1));
    // Bubbles leave prod_valid_q low, so they add nothing to the sum.
    assign acc_sum   = prod_valid_q ? acc_q + ACC_WIDTH'(prod_q) : acc_q;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (rst_in) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first; a missed branch would otherwise infer a latch.
    always_comb begin
        state_d            = state_q;
        bus.data_ready_out = 1'b0;
        bus.busy_out       = 1'b1;
        bus.acc_valid_out  = 1'b0;
        case (state_q)
            IDLE: begin
                bus.busy_out = 1'b0;
                if (bus.start_in)
                    state_d = (bus.num_inputs_in == '0) ? DRAIN : ACCUM;
            end
            ACCUM: begin
                bus.data_ready_out = 1'b1;
                if (last_beat) state_d = DRAIN;
            end
            DRAIN: state_d = DONE;
            DONE: begin
                bus.acc_valid_out = 1'b1;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            count_q      <= '0;
            prod_q       <= '0;
            prod_valid_q <= 1'b0;
            acc_q        <= '0;
            result_q     <= '0;
        end else begin
            prod_valid_q <= accept;
            if (accept) begin
                prod_q  <= PROD_WIDTH'(act_s) * PROD_WIDTH'(wt_s);
                count_q <= count_q - COUNT_WIDTH'(1);
            end
            if (start_ok) begin
                acc_q   <= ACC_WIDTH'(bias_s);
                count_q <= bus.num_inputs_in;
            end else begin
                acc_q <= acc_sum;
            end
            // The final product is still in flight during DRAIN; fold it in as the result is captured.
            if (state_q == DRAIN) result_q <= acc_sum;
        end
    end

    assign bus.acc_data_out = result_q;

endmodule

// File: tb/tb_neuron_accumulator.sv
// Directed bench for neuron_accumulator: every scenario task drives its own
// stimulus and compares against hand-computed expected values.
module tb_neuron_accumulator;
    localparam int DW = 16;
    localparam int AW = 32;
    localparam int CW = 11;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   hs_total = 0;
    int   pulse_total = 0;
    int   ready_total = 0;

    neuron_accumulator_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .COUNT_WIDTH(CW)) bus ();

    neuron_accumulator #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .MAX_INPUTS(1024), .COUNT_WIDTH(CW)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    // Running totals; each test snapshots them and compares the difference.
    always @(posedge clk_in) begin
        if (bus.data_valid_in && bus.data_ready_out) hs_total <= hs_total + 1;
        if (bus.acc_valid_out) pulse_total <= pulse_total + 1;
        if (bus.data_ready_out) ready_total <= ready_total + 1;
    end

    task automatic start_sum(input int n, input int bias);
        bus.start_in      = 1'b1;
        bus.num_inputs_in = CW'(n);
        bus.bias_in       = DW'(bias);
        @(negedge clk_in);
        bus.start_in      = 1'b0;
    endtask

    task automatic beat(input int a, input int w);
        bus.data_valid_in = 1'b1;
        bus.activation_in = DW'(a);
        bus.weight_in     = DW'(w);
        @(negedge clk_in);
        bus.data_valid_in = 1'b0;
    endtask

    task automatic test_reset;
        rst_in = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        vectors++; if (bus.busy_out !== 1'b0 || bus.data_ready_out !== 1'b0 || bus.acc_valid_out !== 1'b0) begin
            miscompares++; $display("FAIL reset_ctrl: got busy=%b ready=%b valid=%b want 0/0/0", bus.busy_out, bus.data_ready_out, bus.acc_valid_out); end
        vectors++; if (bus.acc_data_out !== 32'h0) begin
            miscompares++; $display("FAIL reset_data: got %h want 00000000", bus.acc_data_out); end
        rst_in = 1'b0;
        @(negedge clk_in);
        vectors++; if (bus.busy_out !== 1'b0 || bus.acc_valid_out !== 1'b0) begin
            miscompares++; $display("FAIL reset_release: got busy=%b valid=%b want 0/0", bus.busy_out, bus.acc_valid_out); end
    endtask

    task automatic test_basic;
        int p0;
        p0 = pulse_total;
        start_sum(3, 5);
        vectors++; if (bus.busy_out !== 1'b1 || bus.data_ready_out !== 1'b1) begin
            miscompares++; $display("FAIL basic_start: got busy=%b ready=%b want 1/1", bus.busy_out, bus.data_ready_out); end
        beat(2, 3);
        beat(-4, 5);
        beat(100, 100);
        vectors++; if (bus.data_ready_out !== 1'b0 || bus.acc_valid_out !== 1'b0) begin
            miscompares++; $display("FAIL basic_drain: got ready=%b valid=%b want 0/0", bus.data_ready_out, bus.acc_valid_out); end
        @(negedge clk_in);
        vectors++; if (bus.acc_valid_out !== 1'b1) begin
            miscompares++; $display("FAIL basic_valid: got %b want 1", bus.acc_valid_out); end
        vectors++; if (bus.acc_data_out !== 32'h00002707) begin
            miscompares++; $display("FAIL basic_data: got %h want 00002707", bus.acc_data_out); end
        @(negedge clk_in);
        vectors++; if (bus.acc_valid_out !== 1'b0 || bus.busy_out !== 1'b0 || bus.acc_data_out !== 32'h00002707) begin
            miscompares++; $display("FAIL basic_after: got valid=%b busy=%b data=%h want 0/0/00002707", bus.acc_valid_out, bus.busy_out, bus.acc_data_out); end
        vectors++; if (pulse_total - p0 !== 1) begin
            miscompares++; $display("FAIL basic_pulses: got %0d want 1", pulse_total - p0); end
    endtask

    task automatic test_wrap;
        start_sum(2, 0);
        beat(-32768, -32768);
        beat(-32768, -32768);
        @(negedge clk_in);
        vectors++; if (bus.acc_valid_out !== 1'b1 || bus.acc_data_out !== 32'h80000000) begin
            miscompares++; $display("FAIL wrap_data: got valid=%b data=%h want 1/80000000", bus.acc_valid_out, bus.acc_data_out); end
        @(negedge clk_in);
    endtask

    task automatic test_bias_only;
        int r0;
        r0 = ready_total;
        start_sum(0, -7);
        vectors++; if (bus.busy_out !== 1'b1 || bus.acc_valid_out !== 1'b0) begin
            miscompares++; $display("FAIL bias_drain: got busy=%b valid=%b want 1/0", bus.busy_out, bus.acc_valid_out); end
        @(negedge clk_in);
        vectors++; if (bus.acc_valid_out !== 1'b1 || bus.acc_data_out !== 32'hFFFFFFF9) begin
            miscompares++; $display("FAIL bias_data: got valid=%b data=%h want 1/fffffff9", bus.acc_valid_out, bus.acc_data_out); end
        @(negedge clk_in);
        vectors++; if (ready_total - r0 !== 0) begin
            miscompares++; $display("FAIL bias_ready: got %0d ready cycles want 0", ready_total - r0); end
    endtask

    task automatic test_gaps;
        bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int h0, p0;
        h0 = hs_total;
        p0 = pulse_total;
        start_sum(4, 0);
        for (int i = 0; i < 7; i++) begin
            bus.data_valid_in = pat[i];
            bus.activation_in = DW'(1);
            bus.weight_in     = DW'(1);
            bus.start_in      = (i == 2);
            bus.num_inputs_in = CW'(9);
            bus.bias_in       = DW'(100);
            @(negedge clk_in);
        end
        bus.data_valid_in = 1'b0;
        bus.start_in      = 1'b0;
        vectors++; if (bus.data_ready_out !== 1'b0) begin
            miscompares++; $display("FAIL gaps_ready: got %b want 0", bus.data_ready_out); end
        @(negedge clk_in);
        vectors++; if (bus.acc_valid_out !== 1'b1 || bus.acc_data_out !== 32'd4) begin
            miscompares++; $display("FAIL gaps_data: got valid=%b data=%h want 1/00000004", bus.acc_valid_out, bus.acc_data_out); end
        @(negedge clk_in);
        vectors++; if (hs_total - h0 !== 4) begin
            miscompares++; $display("FAIL gaps_handshakes: got %0d want 4", hs_total - h0); end
        vectors++; if (pulse_total - p0 !== 1 || bus.busy_out !== 1'b0) begin
            miscompares++; $display("FAIL gaps_pulses: got pulses=%0d busy=%b want 1/0", pulse_total - p0, bus.busy_out); end
    endtask

    task automatic test_back_to_back;
        start_sum(2, 10);
        beat(1, 2);
        beat(3, 4);
        @(negedge clk_in);
        vectors++; if (bus.acc_valid_out !== 1'b1 || bus.acc_data_out !== 32'd24) begin
            miscompares++; $display("FAIL b2b_first: got valid=%b data=%h want 1/00000018", bus.acc_valid_out, bus.acc_data_out); end
        @(negedge clk_in);
        vectors++; if (bus.busy_out !== 1'b0) begin
            miscompares++; $display("FAIL b2b_idle: got busy=%b want 0", bus.busy_out); end
        start_sum(1, -2);
        vectors++; if (bus.busy_out !== 1'b1 || bus.acc_data_out !== 32'd24) begin
            miscompares++; $display("FAIL b2b_hold_accum: got busy=%b data=%h want 1/00000018", bus.busy_out, bus.acc_data_out); end
        beat(5, 5);
        vectors++; if (bus.acc_data_out !== 32'd24 || bus.acc_valid_out !== 1'b0) begin
            miscompares++; $display("FAIL b2b_hold_drain: got valid=%b data=%h want 0/00000018", bus.acc_valid_out, bus.acc_data_out); end
        @(negedge clk_in);
        vectors++; if (bus.acc_valid_out !== 1'b1 || bus.acc_data_out !== 32'd23) begin
            miscompares++; $display("FAIL b2b_second: got valid=%b data=%h want 1/00000017", bus.acc_valid_out, bus.acc_data_out); end
        @(negedge clk_in);
    endtask

    task automatic test_abort;
        start_sum(5, 3);
        beat(2, 2);
        beat(2, 2);
        rst_in = 1'b1;
        @(negedge clk_in);
        vectors++; if (bus.busy_out !== 1'b0 || bus.data_ready_out !== 1'b0 || bus.acc_valid_out !== 1'b0 || bus.acc_data_out !== 32'h0) begin
            miscompares++; $display("FAIL abort_reset: got busy=%b ready=%b valid=%b data=%h want 0/0/0/00000000",
                                    bus.busy_out, bus.data_ready_out, bus.acc_valid_out, bus.acc_data_out); end
        rst_in = 1'b0;
        @(negedge clk_in);
        start_sum(1, 1);
        beat(3, 3);
        @(negedge clk_in);
        vectors++; if (bus.acc_valid_out !== 1'b1 || bus.acc_data_out !== 32'd10) begin
            miscompares++; $display("FAIL abort_restart: got valid=%b data=%h want 1/0000000a", bus.acc_valid_out, bus.acc_data_out); end
        @(negedge clk_in);
    endtask

    initial begin
        bus.start_in      = 1'b0;
        bus.num_inputs_in = '0;
        bus.bias_in       = '0;
        bus.data_valid_in = 1'b0;
        bus.activation_in = '0;
        bus.weight_in     = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_bias_only();
        test_gaps();
        test_back_to_back();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/neuron_accumulator.md
# neuron_accumulator

Streaming multiply-accumulate engine that computes one neuron's pre-activation sum: a sign-extended bias plus the sum of N signed activation × weight products. It sits upstream of the saturating output stage. It produces the full-width, un-saturated accumulator word that the output stage later narrows back to the activation width. Inputs arrive over a valid/ready stream; the result leaves as a single-cycle valid pulse with held data.

## Interface
- DATA_WIDTH, 16, width of activations, weights, bias (signed two's complement)
- ACC_WIDTH, 32, accumulator/result width; must be ≥ 2·DATA_WIDTH
- MAX_INPUTS, 1024, largest supported N
- COUNT_WIDTH, $clog2(MAX_INPUTS+1), width of input count

- clk_in  input  1  sole clock; all logic on posedge
- rst_in  input  1  synchronous, active-high reset
- start_in  input  1  begin a new sum; honoured only in IDLE
- num_inputs_in  input  COUNT_WIDTH  N, sampled with start_in; 0 = bias only
- bias_in  input  DATA_WIDTH  signed bias, sampled with start_in
- data_valid_in  input  1  activation/weight pair present
- activation_in  input  DATA_WIDTH  signed activation
- weight_in  input  DATA_WIDTH  signed weight
- data_ready_out  output  1  high only in ACCUM
- busy_out  output  1  high in any state but IDLE
- acc_valid_out  output  1  one-cycle result strobe
- acc_data_out  output  ACC_WIDTH  signed result, held until next start

## Operation
- FSM states: IDLE, ACCUM, DRAIN, DONE.
- IDLE:
  - start_in=1 → load accumulator with sign-extended bias_in.
  - Latch N into remaining-count.
  - Go to ACCUM, or to DRAIN if N=0.
- ACCUM:
  - A beat is accepted on each edge with data_valid_in & data_ready_out.
  - Product = signed activation × signed weight (2·DATA_WIDTH bits), registered into product stage, sign-extended to ACC_WIDTH.
  - Accumulator adds the product stage one edge after acceptance.
  - Remaining-count decrements per accepted beat.
  - Accepting the last beat → DRAIN.
- DRAIN: final product stage added; → DONE.
- DONE: acc_valid_out=1 for exactly this cycle; → IDLE.
- Product stage carries a valid bit. A non-accepted cycle adds nothing (product-valid=0), so gaps in data_valid_in never corrupt the sum.
- Arithmetic wraps modulo 2^ACC_WIDTH; no saturation or overflow flag here (downstream owns saturation).
- data_valid_in outside ACCUM: ignored, no effect.
- start_in outside IDLE: ignored; in-flight sum continues unchanged.
- num_inputs_in > MAX_INPUTS: undefined; caller's responsibility.
- rst_in at any point → IDLE immediately, in-flight sum discarded, next start begins clean.

## Timing
- Reset values: data_ready_out=0, busy_out=0, acc_valid_out=0, acc_data_out=0, accumulator=0, product-valid=0, count=0.
- start edge E: busy_out and data_ready_out high in the cycle after E.
- Throughput: one beat per cycle with continuous valid.
- Last beat accepted on edge L:
  - data_ready_out drops in the cycle after L.
  - acc_valid_out high in the cycle after edge L+1; acc_data_out final from that cycle onward.
- N=0 with start on edge E: DRAIN after E, acc_valid_out high after E+1, value = sign-extended bias.
- Minimum start-to-start spacing: N+3 cycles. busy_out falls in the cycle after the acc_valid_out pulse; start_in may be asserted in that cycle.
- acc_data_out updates only at the DRAIN→DONE edge and is stable otherwise. Reset clears it to 0.

## Test plan
- N=3, bias=5, pairs (2,3),(−4,5),(100,100), valid continuous → single acc_valid_out pulse two cycles after last handshake, acc_data_out=9991 (0x00002707).
- N=2, bias=0, pairs (−32768,−32768) ×2 → acc_data_out=0x80000000 (wrap, no saturation).
- N=0, bias=−7 → acc_valid_out two cycles after start, acc_data_out=0xFFFFFFF9, data_ready_out never high.
- N=4, all pairs (1,1), bias=0, data_valid_in toggled 1-0-0-1-1-0-1 with random gaps → acc_data_out=4, exactly 4 handshakes, start_in pulsed mid-run has no effect.
- N=5, rst_in asserted after 2 beats → all outputs at reset values next cycle. New start N=1, bias=1, pair (3,3) → acc_data_out=10 (no residue from aborted sum).
- Back-to-back: second start in the cycle after the first's acc_valid_out → second result correct, first result held on acc_data_out until the second's DONE.
